mem_access_arbiter: RTL and testbench

// - Sits directly upstream of data_memory: collects per-core load/store requests, resolves

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_access_arbiter_if.sv | 29 ++
 rtl/mem_arb_grant.sv | 72 +++++++
 rtl/mem_access_arbiter.sv | 74 +++++++
 tb/tb_mem_access_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared op codes, default widths and lane helpers for the memory access arbiter
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      OP_NOP     = 2'd0,
      OP_NOP_ALT = 2'd1,
      OP_READ    = 2'd2,
      OP_WRITE   = 2'd3
   } mem_op_e;

   typedef struct packed {
      logic grant;
      logic stall;
      logic err;
   } lane_status_t;

   function automatic int lane_base(input int lane, input int width);
      return lane * width;
   endfunction

   // Only codes 2 and 3 touch memory; bit 1 alone identifies them.
   function automatic logic is_access(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic is_write(input logic [1:0] op);
      return op == OP_WRITE;
   endfunction

endpackage

// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - core request/response lanes and data_memory lanes of the arbiter
interface mem_access_arbiter_if #(
   parameter int NUM_CORES = 16,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16
);
   logic [NUM_CORES-1:0]        req_valid;
   logic [2*NUM_CORES-1:0]      req_op;
   logic [ADDR_W*NUM_CORES-1:0] req_addr;
   logic [DATA_W*NUM_CORES-1:0] req_wdata;
   logic [NUM_CORES-1:0]        req_ready;
   logic [2*NUM_CORES-1:0]      mem_ctrl;
   logic [ADDR_W*NUM_CORES-1:0] mem_addr;
   logic [DATA_W*NUM_CORES-1:0] mem_wdata;
   logic [DATA_W*NUM_CORES-1:0] mem_rdata;
   logic [NUM_CORES-1:0]        rsp_valid;
   logic [DATA_W*NUM_CORES-1:0] rsp_data;
   logic [NUM_CORES-1:0]        rsp_err;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
      output req_ready, mem_ctrl, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, mem_rdata,
      input  req_ready, mem_ctrl, mem_addr, mem_wdata, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - combinational rotated grant scan with same-address hazard resolution
module mem_arb_grant
   import mem_arb_pkg::*;
#(
   parameter int NUM_CORES = 16,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MEM_DEPTH = 256,
   parameter int PTR_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic [NUM_CORES-1:0]        req_valid_i,
   input  logic [2*NUM_CORES-1:0]      req_op_i,
   input  logic [ADDR_W*NUM_CORES-1:0] req_addr_i,
   input  logic [PTR_W-1:0]            rr_ptr_i,
   output logic [NUM_CORES-1:0]        grant_o,
   output logic [NUM_CORES-1:0]        stall_o,
   output logic [NUM_CORES-1:0]        err_o,
   output logic [PTR_W-1:0]            next_ptr_o
);

   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

   logic [1:0]        op_a   [NUM_CORES];
   logic [ADDR_W-1:0] addr_a [NUM_CORES];

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
      assign op_a[g]   = req_op_i[lane_base(g, 2) +: 2];
      assign addr_a[g] = req_addr_i[lane_base(g, ADDR_W) +: ADDR_W];
   end

   // Later lanes in scan order see the grants already made to earlier ones.
   always_comb begin : scan
      logic [PTR_W-1:0] idx;
      logic [PTR_W-1:0] jdx;
      logic             conflict;
      logic             found;
      grant_o    = '0;
      stall_o    = '0;
      err_o      = '0;
      next_ptr_o = rr_ptr_i;
      found      = 1'b0;
      conflict   = 1'b0;
      idx        = '0;
      jdx        = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_CORES);
         if (req_valid_i[idx] && is_access(op_a[idx])) begin
            if ({1'b0, addr_a[idx]} >= DEPTH_X) begin
               err_o[idx] = 1'b1;
            end else begin
               conflict = 1'b0;
               for (int j = 0; j < NUM_CORES; j++) begin
                  jdx = PTR_W'((int'(rr_ptr_i) + j) % NUM_CORES);
                  if (j < k && grant_o[jdx] && addr_a[jdx] == addr_a[idx] &&
                      (is_write(op_a[jdx]) || is_write(op_a[idx]))) begin
                     conflict = 1'b1;
                  end
               end
               if (conflict) begin
                  stall_o[idx] = 1'b1;
                  if (!found) begin
                     found      = 1'b1;
                     next_ptr_o = idx;
                  end
               end else begin
                  grant_o[idx] = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - per-core load/store arbiter in front of data_memory
// Holds the round-robin pointer, per-lane pending flags and drives the memory and response lanes.
module mem_access_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_CORES = 16,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_DEPTH = 256
) (
   input logic                  clk_i,
   input logic                  rst_i,
   mem_access_arbiter_if.slave  bus_io
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_CORES-1:0] rd_pend_q, rd_pend_d;
   logic [NUM_CORES-1:0] wr_pend_q, wr_pend_d;
   logic [NUM_CORES-1:0] err_pend_q, err_pend_d;
   logic [NUM_CORES-1:0] grant, stall;

   mem_arb_grant #(
      .NUM_CORES (NUM_CORES),
      .ADDR_W    (ADDR_W),
      .MEM_DEPTH (MEM_DEPTH),
      .PTR_W     (PTR_W)
   ) u_grant (
      .req_valid_i (bus_io.req_valid),
      .req_op_i    (bus_io.req_op),
      .req_addr_i  (bus_io.req_addr),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (grant),
      .stall_o     (stall),
      .err_o       (err_pend_d),
      .next_ptr_o  (rr_ptr_d)
   );

   assign bus_io.mem_addr  = bus_io.req_addr;
   assign bus_io.mem_wdata = bus_io.req_wdata;

   // Responses are gated by reset so a pending access never answers while reset is held.
   for (genvar g = 0; g < NUM_CORES; g++) begin : g_lane
      logic [1:0] op_g;
      assign op_g = bus_io.req_op[lane_base(g, 2) +: 2];

      assign bus_io.req_ready[g] = !rst_i && bus_io.req_valid[g] && !stall[g];
      assign bus_io.mem_ctrl[lane_base(g, 2) +: 2] = (!rst_i && grant[g]) ? op_g : 2'b00;

      assign rd_pend_d[g] = grant[g] && !is_write(op_g);
      assign wr_pend_d[g] = grant[g] && is_write(op_g);

      assign bus_io.rsp_valid[g] = !rst_i && (rd_pend_q[g] || wr_pend_q[g] || err_pend_q[g]);
      assign bus_io.rsp_err[g]   = !rst_i && err_pend_q[g];
      assign bus_io.rsp_data[lane_base(g, DATA_W) +: DATA_W] =
         (!rst_i && rd_pend_q[g]) ? bus_io.mem_rdata[lane_base(g, DATA_W) +: DATA_W] : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         rd_pend_q  <= '0;
         wr_pend_q  <= '0;
         err_pend_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rd_pend_q  <= rd_pend_d;
         wr_pend_q  <= wr_pend_d;
         err_pend_q <= err_pend_d;
      end
   end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - self-checking bench for mem_access_arbiter with a data_memory model
module tb_mem_access_arbiter;
   import mem_arb_pkg::*;

   localparam int N     = 16;
   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 256;

   typedef struct {
      int          cyc;
      int          lane;
      logic [DW-1:0] data;
      logic        err;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_init_done = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fails = 0;
   rsp_t sb[$];
   rsp_t ent;
   logic [N-1:0]    exp_v, exp_e;
   logic [N*DW-1:0] exp_d;
   logic [DW-1:0]   ram [DEPTH];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_access_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_access_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   // data_memory stand-in: write at the edge, registered read data.
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int a = 0; a < DEPTH; a++) ram[a] <= DW'(a);
         mem_init_done <= 1'b1;
      end else begin
         for (int i = 0; i < N; i++) begin
            logic [AW-1:0] a;
            a = bus.mem_addr[AW*i +: AW];
            if (a < AW'(DEPTH)) begin
               if (bus.mem_ctrl[2*i +: 2] == 2'd3) ram[a[7:0]] <= bus.mem_wdata[DW*i +: DW];
               if (bus.mem_ctrl[2*i +: 2] == 2'd2) bus.mem_rdata[DW*i +: DW] <= ram[a[7:0]];
            end
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
   endtask

   task automatic set_req(input int lane, input logic [1:0] op, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd);
      bus.req_valid[lane]          = 1'b1;
      bus.req_op[2*lane +: 2]      = op;
      bus.req_addr[AW*lane +: AW]  = addr;
      bus.req_wdata[DW*lane +: DW] = wd;
   endtask

   task automatic expect_rsp(input int lane, input logic [DW-1:0] d, input logic e);
      sb.push_back('{cyc + 1, lane, d, e});
   endtask

   task automatic do_reset();
      next_cycle();
      rst = 1'b1;
      clear_reqs();
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      next_cycle();
      rst = 1'b1;
      set_req(0, OP_WRITE, 16'd3, 16'h1234);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== '0) begin n_fails++; $display("FAIL rst_ready actual=%h required=0", bus.req_ready); end
      n_checks++; if (bus.mem_ctrl !== '0) begin n_fails++; $display("FAIL rst_mem_ctrl actual=%h required=0", bus.mem_ctrl); end
      next_cycle();
      rst = 1'b0;
      clear_reqs();
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== '0) begin n_fails++; $display("FAIL rst_rsp_valid actual=%h required=0", bus.rsp_valid); end
      n_checks++; if (bus.rsp_err !== '0) begin n_fails++; $display("FAIL rst_rsp_err actual=%h required=0", bus.rsp_err); end
      n_checks++; if (bus.rsp_data !== '0) begin n_fails++; $display("FAIL rst_rsp_data actual=%h required=0", bus.rsp_data); end
   endtask

   task automatic test_write_conflict();
      next_cycle();
      clear_reqs();
      set_req(0, OP_WRITE, 16'd5, 16'h00AA);
      set_req(1, OP_WRITE, 16'd5, 16'h00BB);
      expect_rsp(0, '0, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0001) begin n_fails++; $display("FAIL wc_ready_t actual=%h required=0001", bus.req_ready); end
      n_checks++; if (bus.mem_ctrl !== 32'h3) begin n_fails++; $display("FAIL wc_ctrl_t actual=%h required=00000003", bus.mem_ctrl); end
      next_cycle();
      clear_reqs();
      set_req(1, OP_WRITE, 16'd5, 16'h00BB);
      expect_rsp(1, '0, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0002) begin n_fails++; $display("FAIL wc_ready_t1 actual=%h required=0002", bus.req_ready); end
      n_checks++; if (bus.mem_ctrl !== 32'hC) begin n_fails++; $display("FAIL wc_ctrl_t1 actual=%h required=0000000c", bus.mem_ctrl); end
      next_cycle();
      clear_reqs();
      @(negedge clk);
      n_checks++; if (ram[5] !== 16'h00BB) begin n_fails++; $display("FAIL wc_ram5 actual=%h required=00bb", ram[5]); end
   endtask

   task automatic test_read_share();
      next_cycle();
      clear_reqs();
      set_req(3, OP_READ, 16'd2, '0);
      set_req(7, OP_READ, 16'd2, '0);
      expect_rsp(3, 16'd2, 1'b0);
      expect_rsp(7, 16'd2, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0088) begin n_fails++; $display("FAIL rr_ready actual=%h required=0088", bus.req_ready); end
      n_checks++; if (bus.mem_ctrl !== 32'h8080) begin n_fails++; $display("FAIL rr_ctrl actual=%h required=00008080", bus.mem_ctrl); end
      next_cycle();
      clear_reqs();
      @(negedge clk);
   endtask

   task automatic test_read_after_write();
      do_reset();
      next_cycle();
      set_req(0, OP_WRITE, 16'd4, 16'd9);
      set_req(1, OP_READ, 16'd4, '0);
      expect_rsp(0, '0, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0001) begin n_fails++; $display("FAIL raw_ready_t actual=%h required=0001", bus.req_ready); end
      n_checks++; if (bus.mem_ctrl !== 32'h3) begin n_fails++; $display("FAIL raw_ctrl_t actual=%h required=00000003", bus.mem_ctrl); end
      next_cycle();
      clear_reqs();
      set_req(1, OP_READ, 16'd4, '0);
      expect_rsp(1, 16'd9, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0002) begin n_fails++; $display("FAIL raw_ready_t1 actual=%h required=0002", bus.req_ready); end
      n_checks++; if (bus.mem_ctrl !== 32'h8) begin n_fails++; $display("FAIL raw_ctrl_t1 actual=%h required=00000008", bus.mem_ctrl); end
      next_cycle();
      clear_reqs();
      @(negedge clk);
      n_checks++; if (bus.rsp_data[31:16] !== 16'd9) begin n_fails++; $display("FAIL raw_rdata1 actual=%h required=0009", bus.rsp_data[31:16]); end
   endtask

   task automatic test_range_and_nop();
      next_cycle();
      clear_reqs();
      set_req(2, OP_READ, 16'd300, '0);
      set_req(4, OP_WRITE, 16'd256, 16'hDEAD);
      set_req(6, OP_READ, 16'd255, '0);
      set_req(8, OP_NOP, 16'd4, 16'h1111);
      set_req(9, OP_NOP_ALT, 16'd4, 16'h2222);
      expect_rsp(2, '0, 1'b1);
      expect_rsp(4, '0, 1'b1);
      expect_rsp(6, 16'd255, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0354) begin n_fails++; $display("FAIL rng_ready actual=%h required=0354", bus.req_ready); end
      n_checks++; if (bus.mem_ctrl !== 32'h2000) begin n_fails++; $display("FAIL rng_ctrl actual=%h required=00002000", bus.mem_ctrl); end
      next_cycle();
      clear_reqs();
      @(negedge clk);
   endtask

   task automatic test_full_contention();
      logic [N-1:0]   exp_rdy;
      logic [2*N-1:0] exp_ctl;
      do_reset();
      for (int k = 0; k < N; k++) begin
         next_cycle();
         if (k == 0) begin
            for (int i = 0; i < N; i++) set_req(i, OP_WRITE, 16'd10, DW'(16'h0100 + i));
         end
         expect_rsp(k, '0, 1'b0);
         exp_rdy = '0;
         exp_rdy[k] = 1'b1;
         exp_ctl = '0;
         exp_ctl[2*k +: 2] = 2'b11;
         @(negedge clk);
         n_checks++; if (bus.req_ready !== exp_rdy) begin n_fails++; $display("FAIL fc_ready k=%0d actual=%h required=%h", k, bus.req_ready, exp_rdy); end
         n_checks++; if (bus.mem_ctrl !== exp_ctl) begin n_fails++; $display("FAIL fc_ctrl k=%0d actual=%h required=%h", k, bus.mem_ctrl, exp_ctl); end
      end
      next_cycle();
      clear_reqs();
      @(negedge clk);
      n_checks++; if (ram[10] !== 16'h010F) begin n_fails++; $display("FAIL fc_ram10 actual=%h required=010f", ram[10]); end
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      next_cycle();
      set_req(3, OP_WRITE, 16'd20, 16'h0033);
      set_req(4, OP_WRITE, 16'd20, 16'h0044);
      expect_rsp(3, '0, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0008) begin n_fails++; $display("FAIL rm_ready_a actual=%h required=0008", bus.req_ready); end
      next_cycle();
      clear_reqs();
      set_req(4, OP_WRITE, 16'd20, 16'h0044);
      set_req(5, OP_READ, 16'd1, '0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0030) begin n_fails++; $display("FAIL rm_ready_b actual=%h required=0030", bus.req_ready); end
      next_cycle();
      rst = 1'b1;
      clear_reqs();
      set_req(0, OP_WRITE, 16'd21, 16'h0077);
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== '0) begin n_fails++; $display("FAIL rm_rsp_valid actual=%h required=0", bus.rsp_valid); end
      n_checks++; if (bus.req_ready !== '0) begin n_fails++; $display("FAIL rm_ready_rst actual=%h required=0", bus.req_ready); end
      n_checks++; if (bus.mem_ctrl !== '0) begin n_fails++; $display("FAIL rm_ctrl_rst actual=%h required=0", bus.mem_ctrl); end
      next_cycle();
      rst = 1'b0;
      clear_reqs();
      @(negedge clk);
      n_checks++; if (bus.rsp_valid !== '0) begin n_fails++; $display("FAIL rm_rsp_after actual=%h required=0", bus.rsp_valid); end
      next_cycle();
      set_req(0, OP_WRITE, 16'd30, 16'h0030);
      set_req(4, OP_WRITE, 16'd30, 16'h0040);
      expect_rsp(0, '0, 1'b0);
      @(negedge clk);
      n_checks++; if (bus.req_ready !== 16'h0001) begin n_fails++; $display("FAIL rm_ptr_reset actual=%h required=0001", bus.req_ready); end
      next_cycle();
      clear_reqs();
      @(negedge clk);
      n_checks++; if (ram[20] !== 16'h0044) begin n_fails++; $display("FAIL rm_ram20 actual=%h required=0044", ram[20]); end
      n_checks++; if (ram[21] !== 16'd21) begin n_fails++; $display("FAIL rm_ram21 actual=%h required=0015", ram[21]); end
   endtask

   initial begin
      clear_reqs();
      fork
         forever begin
            @(negedge clk);
            exp_v = '0;
            exp_e = '0;
            exp_d = '0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
               ent = sb.pop_front();
               if (ent.cyc < cyc) begin
                  n_checks++; n_fails++;
                  $display("FAIL sb_missed lane=%0d due=%0d now=%0d", ent.lane, ent.cyc, cyc);
               end else begin
                  exp_v[ent.lane] = 1'b1;
                  exp_e[ent.lane] = ent.err;
                  exp_d[DW*ent.lane +: DW] = ent.data;
               end
            end
            n_checks++; if (bus.rsp_valid !== exp_v) begin n_fails++; $display("FAIL sb_rsp_valid cyc=%0d actual=%h required=%h", cyc, bus.rsp_valid, exp_v); end
            n_checks++; if (bus.rsp_err !== exp_e) begin n_fails++; $display("FAIL sb_rsp_err cyc=%0d actual=%h required=%h", cyc, bus.rsp_err, exp_e); end
            n_checks++; if (bus.rsp_data !== exp_d) begin n_fails++; $display("FAIL sb_rsp_data cyc=%0d actual=%h required=%h", cyc, bus.rsp_data, exp_d); end
         end
      join_none
      test_reset();
      test_write_conflict();
      test_read_share();
      test_read_after_write();
      test_range_and_nop();
      test_full_contention();
      test_reset_mid_op();
      next_cycle();
      @(negedge clk);
      n_checks++; if (sb.size() != 0) begin n_fails++; $display("FAIL sb_leftover actual=%0d required=0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
